// File: rtl/libv_pkg.sv
// Shared library types: the command encoding understood by the libv deque family.
package libv_pkg;

    typedef enum logic [1:0] {
        OpPushBack  = 2'd0,
        OpPushFront = 2'd1,
        OpPopFront  = 2'd2,
        OpPopBack   = 2'd3
    } deque_op_t;

endpackage

// File: rtl/ob_pkg.sv
// Order-book types shared by the market-order deque and its command sequencer.
package ob_pkg;

    localparam int UID_W   = 8;
    localparam int QTY_W   = 16;
    localparam int ACCUM_W = 20;

    typedef logic [UID_W-1:0]   uid_t;
    typedef logic [QTY_W-1:0]   quantity_t;
    typedef logic [ACCUM_W-1:0] accum_quantity_t;

    typedef struct packed {
        uid_t      uid;
        quantity_t quantity;
    } table_t;

    typedef enum logic {
        MK_ADD  = 1'b0,
        MK_TAKE = 1'b1
    } mk_ctrl_op_t;

    typedef enum logic [1:0] {
        MK_OK     = 2'd0,
        MK_FULL   = 2'd1,
        MK_KILLED = 2'd2,
        MK_BADQTY = 2'd3
    } mk_ctrl_status_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADD     = 3'd1,
        ST_POP     = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_PUSHREM = 3'd4,
        ST_RSP     = 3'd5
    } mk_ctrl_state_t;

endpackage

// File: rtl/ob_mk_ctrl.sv
// Market-order command sequencer: turns ADD/TAKE requests into deque commands,
// filling TAKEs Fill-or-Kill head-first and emitting one fill per touched entry.
//
// Handshake: a request is accepted on a cycle where req_vld && req_rdy; req_rdy
// is high only in IDLE, the requester holds req_* stable until accepted, and
// exactly one rsp_vld strobe answers every accepted request.
module ob_mk_ctrl
    import ob_pkg::*;
    import libv_pkg::*;
#(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_vld,
    output logic            req_rdy,
    input  mk_ctrl_op_t     req_op,
    input  table_t          req_data,
    output logic            dq_cmd_vld,
    output deque_op_t       dq_cmd_op,
    output table_t          dq_cmd_push_data,
    input  logic            dq_head_vld_r,
    input  table_t          dq_head_r,
    input  logic            dq_empty_w,
    input  logic            dq_full_w,
    input  accum_quantity_t dq_quantity_r,
    output logic            fill_vld,
    output uid_t            fill_uid,
    output quantity_t       fill_quantity,
    output logic            rsp_vld,
    output mk_ctrl_status_t rsp_status,
    output mk_ctrl_state_t  dbg_state
);

    mk_ctrl_state_t  state, state_nx;
    quantity_t       rem, rem_nx;
    table_t          hold, hold_nx;
    mk_ctrl_status_t status_nx;

    logic            cmd_vld_nx;
    deque_op_t       cmd_op_nx;
    table_t          push_data_nx;
    logic            fill_vld_nx;
    uid_t            fill_uid_nx;
    quantity_t       fill_qty_nx;

    logic            accept;
    quantity_t       pop_rem;
    logic            head_ok;
    logic            head_whole;

    assign accept     = req_vld && req_rdy;
    // Outputs are registered, so the pop decision is made on entry to POP using
    // the remainder that POP will see: the fresh request or the running rem.
    assign pop_rem    = (state == ST_IDLE) ? req_data.quantity : rem;
    assign head_ok    = dq_head_vld_r && !dq_empty_w;
    assign head_whole = (dq_head_r.quantity <= pop_rem);
    assign dbg_state  = state;

    always_comb begin
        state_nx     = state;
        rem_nx       = rem;
        hold_nx      = hold;
        status_nx    = MK_OK;
        cmd_vld_nx   = 1'b0;
        cmd_op_nx    = OpPushBack;
        push_data_nx = '0;
        fill_vld_nx  = 1'b0;
        fill_uid_nx  = '0;
        fill_qty_nx  = '0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_op == MK_ADD) begin
                        if (req_data.quantity == '0) begin
                            state_nx  = ST_RSP;
                            status_nx = MK_BADQTY;
                        end else if (dq_full_w) begin
                            state_nx  = ST_RSP;
                            status_nx = MK_FULL;
                        end else begin
                            state_nx = ST_ADD;
                            hold_nx  = req_data;
                        end
                    end else begin
                        rem_nx = req_data.quantity;
                        if (req_data.quantity == '0) begin
                            state_nx  = ST_RSP;
                            status_nx = MK_BADQTY;
                        end else if (dq_quantity_r < accum_quantity_t'(req_data.quantity)) begin
                            state_nx  = ST_RSP;
                            status_nx = MK_KILLED;
                        end else begin
                            state_nx = ST_POP;
                        end
                    end
                end
            end
            ST_ADD: begin
                state_nx = ST_RSP;
            end
            ST_POP: begin
                if (!head_ok) begin
                    state_nx  = ST_RSP;
                    status_nx = MK_KILLED;
                end else if (head_whole) begin
                    rem_nx   = rem - dq_head_r.quantity;
                    state_nx = (rem_nx != '0) ? ST_SETTLE : ST_RSP;
                end else begin
                    hold_nx.uid      = dq_head_r.uid;
                    hold_nx.quantity = dq_head_r.quantity - rem;
                    rem_nx           = '0;
                    state_nx         = ST_PUSHREM;
                end
            end
            ST_SETTLE: begin
                state_nx = ST_POP;
            end
            ST_PUSHREM: begin
                state_nx = ST_RSP;
            end
            ST_RSP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Output values for the state being entered.
        case (state_nx)
            ST_ADD: begin
                cmd_vld_nx   = 1'b1;
                cmd_op_nx    = OpPushBack;
                push_data_nx = hold_nx;
            end
            ST_POP: begin
                if (head_ok) begin
                    cmd_vld_nx  = 1'b1;
                    cmd_op_nx   = OpPopFront;
                    fill_vld_nx = 1'b1;
                    fill_uid_nx = dq_head_r.uid;
                    fill_qty_nx = head_whole ? dq_head_r.quantity : pop_rem;
                end
            end
            ST_PUSHREM: begin
                cmd_vld_nx   = 1'b1;
                cmd_op_nx    = OpPushFront;
                push_data_nx = hold_nx;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            rem              <= '0;
            hold             <= '0;
            req_rdy          <= 1'b0;
            dq_cmd_vld       <= 1'b0;
            dq_cmd_op        <= OpPushBack;
            dq_cmd_push_data <= '0;
            fill_vld         <= 1'b0;
            fill_uid         <= '0;
            fill_quantity    <= '0;
            rsp_vld          <= 1'b0;
            rsp_status       <= MK_OK;
        end else begin
            state            <= state_nx;
            rem              <= rem_nx;
            hold             <= hold_nx;
            req_rdy          <= (state_nx == ST_IDLE);
            dq_cmd_vld       <= cmd_vld_nx;
            dq_cmd_op        <= cmd_op_nx;
            dq_cmd_push_data <= push_data_nx;
            fill_vld         <= fill_vld_nx;
            fill_uid         <= fill_uid_nx;
            fill_quantity    <= fill_qty_nx;
            rsp_vld          <= (state_nx == ST_RSP);
            rsp_status       <= (state_nx == ST_RSP) ? status_nx : MK_OK;
        end
    end

    // Per-request fill bookkeeping, used only to check the FOK invariants.
    logic                       trk_take;
    quantity_t                  trk_want;
    accum_quantity_t            trk_got;
    logic [$clog2(N+1):0]       trk_fills;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_take  <= 1'b0;
            trk_want  <= '0;
            trk_got   <= '0;
            trk_fills <= '0;
        end else if (accept) begin
            trk_take  <= (req_op == MK_TAKE);
            trk_want  <= req_data.quantity;
            trk_got   <= '0;
            trk_fills <= '0;
        end else if (fill_vld) begin
            trk_got   <= trk_got + accum_quantity_t'(fill_quantity);
            trk_fills <= trk_fills + 1'b1;
        end
    end

    a_no_cmd_idle_rsp: assert property (@(posedge clk) disable iff (!rst)
        dq_cmd_vld |-> !(state inside {ST_IDLE, ST_RSP}));

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        (dq_cmd_vld && (dq_cmd_op == OpPushBack || dq_cmd_op == OpPushFront)) |-> !dq_full_w);

    a_head_present: assert property (@(posedge clk) disable iff (!rst)
        (state == ST_POP) |-> head_ok);

    a_fill_bound: assert property (@(posedge clk) disable iff (!rst)
        32'(trk_fills) <= N);

    a_fok_sum: assert property (@(posedge clk) disable iff (!rst)
        (rsp_vld && trk_take && rsp_status == MK_OK) |-> (trk_got == accum_quantity_t'(trk_want)));

endmodule

// File: tb/tb_ob_mk_ctrl.sv
// Directed bench for ob_mk_ctrl against a behavioural market-order deque with
// registered status; expected commands, fills and responses go through queues.
module tb_ob_mk_ctrl;
  import ob_pkg::*;
  import libv_pkg::*;

  localparam int N = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            req_vld;
  logic            req_rdy;
  mk_ctrl_op_t     req_op;
  table_t          req_data;
  logic            dq_cmd_vld;
  deque_op_t       dq_cmd_op;
  table_t          dq_cmd_push_data;
  logic            dq_head_vld_r = 1'b0;
  table_t          dq_head_r = '0;
  logic            dq_empty_w;
  logic            dq_full_w;
  accum_quantity_t dq_quantity_r = '0;
  logic            fill_vld;
  uid_t            fill_uid;
  quantity_t       fill_quantity;
  logic            rsp_vld;
  mk_ctrl_status_t rsp_status;
  mk_ctrl_state_t  dbg_state;

  ob_mk_ctrl #(.N(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_vld          (req_vld),
    .req_rdy          (req_rdy),
    .req_op           (req_op),
    .req_data         (req_data),
    .dq_cmd_vld       (dq_cmd_vld),
    .dq_cmd_op        (dq_cmd_op),
    .dq_cmd_push_data (dq_cmd_push_data),
    .dq_head_vld_r    (dq_head_vld_r),
    .dq_head_r        (dq_head_r),
    .dq_empty_w       (dq_empty_w),
    .dq_full_w        (dq_full_w),
    .dq_quantity_r    (dq_quantity_r),
    .fill_vld         (fill_vld),
    .fill_uid         (fill_uid),
    .fill_quantity    (fill_quantity),
    .rsp_vld          (rsp_vld),
    .rsp_status       (rsp_status),
    .dbg_state        (dbg_state)
  );

  // behavioural deque: commands applied at the clock edge, status registered
  table_t dq_m[$];
  int     dq_cnt = 0;
  assign dq_empty_w = (dq_cnt == 0);
  assign dq_full_w  = (dq_cnt == N);

  always @(posedge clk) begin : dq_model
    int s;
    if (dq_cmd_vld) begin
      case (dq_cmd_op)
        OpPushBack:  if (dq_m.size() < N) dq_m.push_back(dq_cmd_push_data);
        OpPushFront: if (dq_m.size() < N) dq_m.push_front(dq_cmd_push_data);
        OpPopFront:  if (dq_m.size() > 0) void'(dq_m.pop_front());
        default:     if (dq_m.size() > 0) void'(dq_m.pop_back());
      endcase
    end
    s = 0;
    foreach (dq_m[i]) s += int'(dq_m[i].quantity);
    dq_cnt        <= dq_m.size();
    dq_head_vld_r <= (dq_m.size() != 0);
    dq_head_r     <= (dq_m.size() != 0) ? dq_m[0] : '0;
    dq_quantity_r <= accum_quantity_t'(s);
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [25:0] exp_cmd_q[$];
  logic [23:0] exp_fill_q[$];
  logic [1:0]  exp_rsp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic exp_cmd(input deque_op_t op, input uid_t u, input quantity_t q);
    exp_cmd_q.push_back({op, u, q});
  endtask

  task automatic exp_fill(input uid_t u, input quantity_t q);
    exp_fill_q.push_back({u, q});
  endtask

  task automatic exp_rsp(input mk_ctrl_status_t st);
    exp_rsp_q.push_back(st);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [25:0] ec;
    if (rst) begin
      if (dq_cmd_vld) begin
        if (exp_cmd_q.size() == 0) unexpected("cmd_unexpected", {dq_cmd_op, dq_cmd_push_data});
        else begin
          ec = exp_cmd_q.pop_front();
          check("cmd_op", dq_cmd_op, ec[25:24]);
          if (ec[25:24] == OpPushBack || ec[25:24] == OpPushFront)
            check("cmd_push_data", dq_cmd_push_data, ec[23:0]);
        end
      end
      if (fill_vld) begin
        if (exp_fill_q.size() == 0) unexpected("fill_unexpected", {fill_uid, fill_quantity});
        else check("fill", {fill_uid, fill_quantity}, exp_fill_q.pop_front());
      end
      if (rsp_vld) begin
        if (exp_rsp_q.size() == 0) unexpected("rsp_unexpected", rsp_status);
        else check("rsp_status", rsp_status, exp_rsp_q.pop_front());
      end
    end
  end

  // driver: issue one request, wait for its response, check accept-to-response latency
  task automatic do_req(input string name, input mk_ctrl_op_t op, input uid_t u,
                        input quantity_t q, input int exp_lat);
    int n;
    int lat;
    @(negedge clk);
    req_vld = 1'b1;
    req_op = op;
    req_data.uid = u;
    req_data.quantity = q;
    n = 0;
    while (!req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy) begin
      unexpected({name, "_accept_timeout"}, n);
      req_vld = 1'b0;
      return;
    end
    @(negedge clk);
    req_vld = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int n;
    req_vld = 1'b0;
    req_op = MK_ADD;
    req_data = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_cmd_vld", dq_cmd_vld, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_rdy", req_rdy, 1);

    // three ADDs
    exp_cmd(OpPushBack, 8'd1, 16'd10); exp_rsp(MK_OK);
    do_req("add1", MK_ADD, 8'd1, 16'd10, 2);
    exp_cmd(OpPushBack, 8'd2, 16'd5); exp_rsp(MK_OK);
    do_req("add2", MK_ADD, 8'd2, 16'd5, 2);
    exp_cmd(OpPushBack, 8'd3, 16'd7); exp_rsp(MK_OK);
    do_req("add3", MK_ADD, 8'd3, 16'd7, 2);
    check("pool_after_adds", dq_quantity_r, 22);

    // TAKE 15: two whole entries, exact finish
    exp_cmd(OpPopFront, 8'd0, 16'd0); exp_fill(8'd1, 16'd10);
    exp_cmd(OpPopFront, 8'd0, 16'd0); exp_fill(8'd2, 16'd5);
    exp_rsp(MK_OK);
    do_req("take15", MK_TAKE, 8'd0, 16'd15, 4);
    check("pool_after_take15", dq_quantity_r, 7);
    check("head_after_take15", dq_head_r.uid, 3);

    // TAKE 4: partial fill with remainder pushed back at the head
    exp_cmd(OpPopFront, 8'd0, 16'd0); exp_fill(8'd3, 16'd4);
    exp_cmd(OpPushFront, 8'd3, 16'd3);
    exp_rsp(MK_OK);
    do_req("take4", MK_TAKE, 8'd0, 16'd4, 3);
    check("pool_after_take4", dq_quantity_r, 3);
    check("head_after_take4", dq_head_r, {8'd3, 16'd3});

    // TAKE 50: killed, no deque traffic
    exp_rsp(MK_KILLED);
    do_req("take50", MK_TAKE, 8'd0, 16'd50, 1);
    check("pool_after_kill", dq_quantity_r, 3);

    // fill the pool to N entries: uid 10..16, qty 1..7
    for (int i = 0; i < 7; i++) begin
      exp_cmd(OpPushBack, uid_t'(10 + i), quantity_t'(i + 1)); exp_rsp(MK_OK);
      do_req("add_fill", MK_ADD, uid_t'(10 + i), quantity_t'(i + 1), 2);
    end
    check("full_w", dq_full_w, 1);
    check("pool_full_qty", dq_quantity_r, 31);

    exp_rsp(MK_FULL);
    do_req("add_full", MK_ADD, 8'd20, 16'd9, 1);
    exp_rsp(MK_BADQTY);
    do_req("add_zero", MK_ADD, 8'd21, 16'd0, 1);
    exp_rsp(MK_BADQTY);
    do_req("take_zero", MK_TAKE, 8'd0, 16'd0, 1);
    check("pool_unchanged", dq_quantity_r, 31);

    // reset in the cycle after the first fill of a two-entry TAKE
    exp_cmd(OpPopFront, 8'd0, 16'd0); exp_fill(8'd3, 16'd3);
    @(negedge clk);
    req_vld = 1'b1;
    req_op = MK_TAKE;
    req_data = {8'd0, 16'd4};
    n = 0;
    while (!req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_vld = 1'b0;
    n = 0;
    while (!fill_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_take_fill_seen", fill_vld, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_outputs",
          {req_rdy, dq_cmd_vld, dq_cmd_op, fill_vld, rsp_vld, rsp_status}, 0);
    check("mid_rst_data", {dq_cmd_push_data, fill_uid, fill_quantity}, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_mid_rst_req_rdy", req_rdy, 1);
    check("post_mid_rst_state", dbg_state, ST_IDLE);
    check("pool_after_abandon", dq_quantity_r, 28);
    check("head_after_abandon", dq_head_r.uid, 10);

    // recovery: TAKE 1 consumes uid 10 exactly
    exp_cmd(OpPopFront, 8'd0, 16'd0); exp_fill(8'd10, 16'd1);
    exp_rsp(MK_OK);
    do_req("take1", MK_TAKE, 8'd0, 16'd1, 2);
    check("pool_after_take1", dq_quantity_r, 27);

    // final report
    repeat (3) @(negedge clk);
    check("cmd_q_drained", exp_cmd_q.size(), 0);
    check("fill_q_drained", exp_fill_q.size(), 0);
    check("rsp_q_drained", exp_rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
